// File: rtl/mmio_pkg.sv
// mmio_pkg: shared types and constants for the MMIO AXI4-Lite master.
// Register indices mirror the slave register map at MMIO_BASE.
package mmio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_A,
    READ_D,
    RESP
  } state_e;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  localparam logic [31:0] MMIO_BASE = 32'h7000_0000;

  localparam int REG_ID     = 0;
  localparam int REG_CTRL   = 1;
  localparam int REG_STATUS = 2;
  localparam int REG_DATA   = 3;
  localparam int REG_IRQ    = 4;

  function automatic logic [31:0] reg_addr(input int idx);
    return MMIO_BASE | 32'(idx << 2);
  endfunction

endpackage

// File: rtl/mmio_timeout_ctr.sv
// mmio_timeout_ctr: saturating cycle counter with a sticky limit flag.
// TIMEOUT of 0 disables the flag entirely.
module mmio_timeout_ctr #(
  parameter int TIMEOUT = 1024
) (
  input  logic fclk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic flag_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_q, flag_d;

  // count up while enabled, hold at LIMIT; flag sticks once LIMIT is hit
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
    flag_d = flag_q || ((TIMEOUT > 0) && (cnt_d == LIMIT));
  end

  // counter and flag registers
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/mmio_lite_master.sv
// mmio_lite_master: single-outstanding AXI4-Lite initiator.
// One command in, one AXI-Lite transaction, one response out.
module mmio_lite_master
  import mmio_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int          TIMEOUT  = 1024,
  parameter logic [31:0] CMD_BASE = MMIO_BASE
) (
  input  logic                fclk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                busy,
  output logic                timeout_err,
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  output logic [ADDR_W-1:0]   M_AXI_ARADDR,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY
);

  localparam int STRB_W = DATA_W / 8;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        resp_q, resp_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;
  logic tmo_clr, tmo_en;

  assign aw_hs  = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs   = M_AXI_WVALID && M_AXI_WREADY;
  assign b_hs   = M_AXI_BVALID && M_AXI_BREADY;
  assign ar_hs  = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_hs   = M_AXI_RVALID && M_AXI_RREADY;
  assign rsp_hs = rsp_valid && rsp_ready;

  // state register
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = cmd_write ? WRITE : READ_A;
      WRITE:   if (b_hs) state_d = RESP;
      READ_A:  if (ar_hs) state_d = READ_D;
      READ_D:  if (r_hs) state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // handshake outputs, all derived from registered state and flags;
  // BREADY waits for both AW and W so an early B is held off
  always_comb begin
    cmd_ready     = 1'b0;
    busy          = 1'b1;
    rsp_valid     = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      WRITE: begin
        M_AXI_AWVALID = !aw_done_q;
        M_AXI_WVALID  = !w_done_q;
        M_AXI_BREADY  = aw_done_q && w_done_q;
      end
      READ_A:  M_AXI_ARVALID = 1'b1;
      READ_D:  M_AXI_RREADY  = 1'b1;
      RESP:    rsp_valid     = 1'b1;
      default: busy          = 1'b0;
    endcase
  end

  // command capture, channel-done tracking and response latching
  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    write_d   = write_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr | ADDR_W'(CMD_BASE);
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          write_d   = cmd_write;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WRITE: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs) w_done_d = 1'b1;
        if (b_hs) begin
          resp_d  = M_AXI_BRESP;
          rdata_d = '0;
        end
      end
      READ_D: begin
        if (r_hs) begin
          resp_d  = M_AXI_RRESP;
          rdata_d = M_AXI_RDATA;
        end
      end
      default: ;
    endcase
  end

  // datapath registers
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= AXI_OKAY;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      write_q   <= write_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = wstrb_q;
  assign rsp_write    = write_q;
  assign rsp_rdata    = rdata_q;
  assign rsp_resp     = resp_q;

  // the watchdog restarts on every state change and only runs while
  // waiting on the slave, never while the requester holds off the response
  assign tmo_clr = (state_d != state_q);
  assign tmo_en  = (state_q == WRITE) || (state_q == READ_A) ||
                   (state_q == READ_D);

  mmio_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .fclk  (fclk),
    .rst_n (rst_n),
    .clr_i (tmo_clr),
    .en_i  (tmo_en),
    .flag_o(timeout_err)
  );

endmodule

// File: tb/tb_mmio_lite_master.sv
// tb_mmio_lite_master: directed bench with a hand-driven AXI-Lite slave.
// Expected values are hand-computed per vector.
module tb_mmio_lite_master;
  import mmio_pkg::*;

  logic        fclk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy, timeout_err;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;

  int n_vec = 0;
  int n_bad = 0;

  mmio_lite_master #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(8)
  ) dut (
    .fclk         (fclk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_write    (rsp_write),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .M_AXI_AWADDR (awaddr),
    .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA  (wdata),
    .M_AXI_WSTRB  (wstrb),
    .M_AXI_WVALID (wvalid),
    .M_AXI_WREADY (wready),
    .M_AXI_BRESP  (bresp),
    .M_AXI_BVALID (bvalid),
    .M_AXI_BREADY (bready),
    .M_AXI_ARADDR (araddr),
    .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA  (rdata),
    .M_AXI_RRESP  (rresp),
    .M_AXI_RVALID (rvalid),
    .M_AXI_RREADY (rready)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, exp finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
    chk("busy_clear", 32'(busy), 32'd0);
  endtask

  task automatic wr_zw(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] exp_a,
                       input logic [1:0] br);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    chk("wr_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("wr_awvalid", 32'(awvalid), 32'd1);
    chk("wr_wvalid", 32'(wvalid), 32'd1);
    chk("wr_awaddr", awaddr, exp_a);
    chk("wr_wdata", wdata, d);
    chk("wr_wstrb", 32'(wstrb), 32'(s));
    chk("wr_bready_early", 32'(bready), 32'd0);
    chk("wr_busy", 32'(busy), 32'd1);
    chk("wr_rsp_c1", 32'(rsp_valid), 32'd0);
    awready = 1'b1;
    wready  = 1'b1;
    tick();
    awready = 1'b0;
    wready  = 1'b0;
    chk("wr_awvalid_drop", 32'(awvalid), 32'd0);
    chk("wr_wvalid_drop", 32'(wvalid), 32'd0);
    chk("wr_bready", 32'(bready), 32'd1);
    chk("wr_rsp_c2", 32'(rsp_valid), 32'd0);
    bvalid = 1'b1;
    bresp  = br;
    tick();
    bvalid = 1'b0;
    bresp  = 2'b00;
    chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr_rsp_write", 32'(rsp_write), 32'd1);
    chk("wr_rsp_resp", 32'(rsp_resp), 32'(br));
    chk("wr_rsp_rdata", rsp_rdata, 32'd0);
    consume();
  endtask

  task automatic rd_zw(input logic [31:0] a, input logic [31:0] exp_a,
                       input logic [31:0] d, input logic [1:0] rr);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = a;
    tick();
    cmd_valid = 1'b0;
    chk("rd_arvalid", 32'(arvalid), 32'd1);
    chk("rd_araddr", araddr, exp_a);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("rd_rready", 32'(rready), 32'd1);
    rvalid = 1'b1;
    rdata  = d;
    rresp  = rr;
    tick();
    rvalid = 1'b0;
    rdata  = 32'd0;
    rresp  = 2'b00;
    chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_rsp_write", 32'(rsp_write), 32'd0);
    chk("rd_rsp_rdata", rsp_rdata, d);
    chk("rd_rsp_resp", 32'(rsp_resp), 32'(rr));
    consume();
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'd0;
    cmd_wdata = 32'd0;
    cmd_wstrb = 4'd0;
    rsp_ready = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    bresp     = 2'b00;
    arready   = 1'b0;
    rvalid    = 1'b0;
    rdata     = 32'd0;
    rresp     = 2'b00;
    tick();
    tick();

    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_awvalid", 32'(awvalid), 32'd0);
    chk("rst_wvalid", 32'(wvalid), 32'd0);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_bready", 32'(bready), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);
    chk("rst_awaddr", awaddr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // zero-wait write
    wr_zw(32'h08, 32'hDEAD_BEEF, 4'hF, 32'h7000_0008, AXI_OKAY);

    // W accepted 4 cycles before AW, B pre-asserted
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h0C;
    cmd_wdata = 32'hA5A5_5A5A;
    cmd_wstrb = 4'h3;
    tick();
    cmd_valid = 1'b0;
    wready    = 1'b1;
    bvalid    = 1'b1;
    bresp     = AXI_OKAY;
    chk("ow_bready_c1", 32'(bready), 32'd0);
    tick();
    wready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ow_wvalid_drop", 32'(wvalid), 32'd0);
      chk("ow_awvalid_hold", 32'(awvalid), 32'd1);
      chk("ow_awaddr_hold", awaddr, 32'h7000_000C);
      chk("ow_bready_off", 32'(bready), 32'd0);
      if (i < 3) tick();
    end
    awready = 1'b1;
    tick();
    awready = 1'b0;
    chk("ow_awvalid_drop", 32'(awvalid), 32'd0);
    chk("ow_bready_on", 32'(bready), 32'd1);
    chk("ow_rsp_early", 32'(rsp_valid), 32'd0);
    tick();
    bvalid = 1'b0;
    chk("ow_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("ow_rsp_resp", 32'(rsp_resp), 32'd0);
    chk("ow_bready_after", 32'(bready), 32'd0);
    consume();
    tick();
    chk("ow_single_rsp", 32'(rsp_valid), 32'd0);

    // read with ARREADY delayed 2 cycles, then response back-pressure
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h10;
    tick();
    cmd_valid = 1'b0;
    chk("rd2_arvalid_c1", 32'(arvalid), 32'd1);
    chk("rd2_araddr", araddr, 32'h7000_0010);
    tick();
    chk("rd2_arvalid_c2", 32'(arvalid), 32'd1);
    tick();
    chk("rd2_arvalid_c3", 32'(arvalid), 32'd1);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("rd2_arvalid_drop", 32'(arvalid), 32'd0);
    chk("rd2_rready", 32'(rready), 32'd1);
    rvalid = 1'b1;
    rdata  = 32'h1234_5678;
    rresp  = AXI_OKAY;
    tick();
    rvalid = 1'b0;
    rdata  = 32'd0;
    chk("rd2_rready_drop", 32'(rready), 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("rd2_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rd2_rsp_rdata", rsp_rdata, 32'h1234_5678);
      chk("rd2_rsp_resp", 32'(rsp_resp), 32'd0);
      chk("rd2_cmd_ready", 32'(cmd_ready), 32'd0);
      if (i < 5) tick();
    end
    consume();

    // slave error passes through
    rd_zw(32'hFFC, 32'h7000_0FFC, 32'hBAD0_0BAD, AXI_SLVERR);
    chk("slverr_tmo", 32'(timeout_err), 32'd0);
    wr_zw(32'h14, 32'h0000_00FF, 4'h1, 32'h7000_0014, AXI_DECERR);

    // AW stalls past TIMEOUT=8, then completes
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h04;
    cmd_wdata = 32'h0000_0011;
    cmd_wstrb = 4'hF;
    tick();
    cmd_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk("tmo_not_yet", 32'(timeout_err), 32'd0);
      tick();
    end
    chk("tmo_set", 32'(timeout_err), 32'd1);
    chk("tmo_awvalid", 32'(awvalid), 32'd1);
    chk("tmo_wvalid", 32'(wvalid), 32'd1);
    tick();
    tick();
    chk("tmo_awvalid_sat", 32'(awvalid), 32'd1);
    awready = 1'b1;
    wready  = 1'b1;
    tick();
    awready = 1'b0;
    wready  = 1'b0;
    chk("tmo_bready", 32'(bready), 32'd1);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    chk("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("tmo_sticky", 32'(timeout_err), 32'd1);
    consume();
    chk("tmo_sticky_idle", 32'(timeout_err), 32'd1);

    // asynchronous reset while ARVALID is up
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h20;
    tick();
    cmd_valid = 1'b0;
    chk("ar_pre_rst", 32'(arvalid), 32'd1);
    chk("busy_pre_rst", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_async_rst", 32'(arvalid), 32'd0);
    chk("busy_async_rst", 32'(busy), 32'd0);
    chk("tmo_async_rst", 32'(timeout_err), 32'd0);
    chk("cmd_ready_rst", 32'(cmd_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("araddr_after_rst", araddr, 32'd0);

    // back-to-back commands after reset
    wr_zw(32'h30, 32'h0000_0001, 4'hF, 32'h7000_0030, AXI_OKAY);
    rd_zw(32'h34, 32'h7000_0034, 32'hCAFE_F00D, AXI_OKAY);
    wr_zw(32'h38, 32'h8000_0000, 4'h8, 32'h7000_0038, AXI_OKAY);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
